// File: rtl/serpent_round_ctrl.sv
// -----------------------------------------------------------------------------
// serpent_round_ctrl
//
// Iterative Serpent-128 encryption datapath and its controller. One round
// is computed per clock. The subkeys come from an external synchronous RAM
// that has a read latency of one cycle. The controller walks rk_addr through
// 0..32 one cycle ahead of the data. A PRIME cycle fills the RAM pipeline
// before the first round.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   start_valid  : plaintext offered
//   start_ready  : high only in IDLE (registered)
//   pt_in        : plaintext {X3,X2,X1,X0}, X0 in bits [31:0]
//   rk_addr      : subkey index driven to the subkey RAM (registered)
//   rk_data      : subkey K[rk_addr of the previous cycle]
//   ct_valid     : ciphertext available (registered)
//   ct_ready     : consumer accepts the ciphertext
//   ct_out       : ciphertext {Y3,Y2,Y1,Y0} (registered, held until next block)
//   busy         : high in every state except IDLE (registered)
// -----------------------------------------------------------------------------
module serpent_round_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [127:0] pt_in,
    output logic [5:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic         ct_valid,
    input  logic         ct_ready,
    output logic [127:0] ct_out,
    output logic         busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Each S-box is packed as 16 nibbles. Entry 0 sits in the most
    // significant nibble, so each constant reads like the published table.
    localparam logic [63:0] SBOX0 = 64'h38F1_A65B_ED42_709C;
    localparam logic [63:0] SBOX1 = 64'hFC27_905A_1BE8_6D34;
    localparam logic [63:0] SBOX2 = 64'h8679_3CAF_D1E4_0B52;
    localparam logic [63:0] SBOX3 = 64'h0FB8_C963_D124_A75E;
    localparam logic [63:0] SBOX4 = 64'h1F83_C0B6_254A_9E7D;
    localparam logic [63:0] SBOX5 = 64'hF52B_4A9C_03E8_D671;
    localparam logic [63:0] SBOX6 = 64'h72C5_846B_E91F_D3A0;
    localparam logic [63:0] SBOX7 = 64'h1DF0_E82B_74CA_9356;

    localparam logic [4:0] LAST_ROUND = 5'd31;
    localparam logic [5:0] LAST_KEY   = 6'd32;

    // -------------------------------------------------------------------------
    // Datapath helper functions
    // -------------------------------------------------------------------------

    // 32-bit rotate left. A shift amount of 0 makes the right shift 32, and
    // that term is then zero, so n = 0 also gives the correct result.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    // One 4-bit S-box lookup. sel selects S0..S7.
    function automatic logic [3:0] sbox_nib(input logic [2:0] sel, input logic [3:0] x);
        logic [63:0] tbl;
        logic [5:0]  top;
        case (sel)
            3'd0:    tbl = SBOX0;
            3'd1:    tbl = SBOX1;
            3'd2:    tbl = SBOX2;
            3'd3:    tbl = SBOX3;
            3'd4:    tbl = SBOX4;
            3'd5:    tbl = SBOX5;
            3'd6:    tbl = SBOX6;
            3'd7:    tbl = SBOX7;
            default: tbl = SBOX0;
        endcase
        top = 6'd63 - {x, 2'b00};
        return tbl[top -: 4];
    endfunction

    // Bitsliced S-box layer. Bit i of the four words forms one nibble, and
    // the bit from X0 is the least significant bit of that nibble.
    function automatic logic [127:0] sbox_layer(input logic [2:0] sel, input logic [127:0] s);
        logic [127:0] y;
        logic [3:0]   nib;
        logic [3:0]   sub;
        y = 128'd0;
        for (int i = 0; i < 32; i++) begin
            nib = {s[96 + i], s[64 + i], s[32 + i], s[i]};
            sub = sbox_nib(sel, nib);
            y[i]      = sub[0];
            y[32 + i] = sub[1];
            y[64 + i] = sub[2];
            y[96 + i] = sub[3];
        end
        return y;
    endfunction

    // Serpent linear transform on {X3,X2,X1,X0}.
    function automatic logic [127:0] lin_transform(input logic [127:0] s);
        logic [31:0] x0;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] x3;
        x0 = s[31:0];
        x1 = s[63:32];
        x2 = s[95:64];
        x3 = s[127:96];
        x0 = rotl32(x0, 5'd13);
        x2 = rotl32(x2, 5'd3);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = rotl32(x1, 5'd1);
        x3 = rotl32(x3, 5'd7);
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = rotl32(x0, 5'd5);
        x2 = rotl32(x2, 5'd22);
        return {x3, x2, x1, x0};
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t       r_fsm;
    logic [4:0]   r_round;
    logic [5:0]   r_rk_addr;
    logic [127:0] r_state;
    logic [127:0] r_ct_out;
    logic         r_ct_valid;
    logic         r_start_ready;
    logic         r_busy;

    // -------------------------------------------------------------------------
    // Combinational next values
    // -------------------------------------------------------------------------
    logic [127:0] w_mixed;
    logic [127:0] w_sub;
    logic [127:0] w_lt;
    logic [127:0] w_round_next;
    logic [127:0] w_final;
    logic [5:0]   w_rk_addr_inc;

    // Round function, last-round bypass of LT, final whitening and subkey address step
    always_comb begin
        w_mixed = r_state ^ rk_data;
        // r[2:0] selects S_(r mod 8). Round 31 therefore uses S7 with no extra logic.
        w_sub   = sbox_layer(r_round[2:0], w_mixed);
        w_lt    = lin_transform(w_sub);
        if (r_round == LAST_ROUND) begin
            w_round_next = w_sub;
        end else begin
            w_round_next = w_lt;
        end
        w_final = r_state ^ rk_data;
        // The address stops at the last subkey. It is still at 32 when FINAL reads K32.
        if (r_rk_addr < LAST_KEY) begin
            w_rk_addr_inc = r_rk_addr + 6'd1;
        end else begin
            w_rk_addr_inc = r_rk_addr;
        end
    end

    // Controller FSM with all datapath and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm         <= ST_IDLE;
            r_round       <= 5'd0;
            r_rk_addr     <= 6'd0;
            r_state       <= 128'd0;
            r_ct_out      <= 128'd0;
            r_ct_valid    <= 1'b0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (start_valid && r_start_ready) begin
                        r_state       <= pt_in;
                        r_rk_addr     <= 6'd0;
                        r_round       <= 5'd0;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_fsm         <= ST_PRIME;
                    end else begin
                        r_fsm <= ST_IDLE;
                    end
                end
                // Only address 0 is issued here. rk_data is not yet valid.
                ST_PRIME: begin
                    r_rk_addr <= w_rk_addr_inc;
                    r_fsm     <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_state   <= w_round_next;
                    r_rk_addr <= w_rk_addr_inc;
                    if (r_round == LAST_ROUND) begin
                        r_fsm <= ST_FINAL;
                    end else begin
                        r_round <= r_round + 5'd1;
                        r_fsm   <= ST_ROUND;
                    end
                end
                ST_FINAL: begin
                    r_state    <= w_final;
                    r_ct_out   <= w_final;
                    r_ct_valid <= 1'b1;
                    r_fsm      <= ST_DONE;
                end
                ST_DONE: begin
                    if (ct_ready) begin
                        r_ct_valid    <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_busy        <= 1'b0;
                        r_fsm         <= ST_IDLE;
                    end else begin
                        r_fsm <= ST_DONE;
                    end
                end
                default: begin
                    r_fsm         <= ST_IDLE;
                    r_round       <= 5'd0;
                    r_rk_addr     <= 6'd0;
                    r_ct_valid    <= 1'b0;
                    r_start_ready <= 1'b1;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready = r_start_ready;
    assign rk_addr     = r_rk_addr;
    assign ct_valid    = r_ct_valid;
    assign ct_out      = r_ct_out;
    assign busy        = r_busy;

endmodule

// File: tb/tb_serpent_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serpent_round_ctrl
//
// Table-driven bench for serpent_round_ctrl. Each table record gives:
//   - the plaintext, the subkey pattern and the consumer stall;
//   - an optional ignored start pulse or mid-round reset;
//   - the expected latency and the expected ct_valid length.
// A reference encryptor built from the published S-box tables supplies the
// expected ciphertext. A synchronous one-cycle subkey RAM feeds rk_data.
// -----------------------------------------------------------------------------
module tb_serpent_round_ctrl;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [127:0] pt_in;
    logic [5:0]   rk_addr;
    logic [127:0] rk_data;
    logic         ct_valid;
    logic         ct_ready;
    logic [127:0] ct_out;
    logic         busy;

    int n_checks;
    int n_fail;

    logic [127:0] ram [0:32];

    int sb [0:7][0:15] = '{
        '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
        '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
        '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
        '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
        '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
        '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
        '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
        '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
    };

    typedef struct {
        logic [127:0] pt;
        int           key_mode;   // 0: zeros, 1: K_n = {4{n}}, 2: random
        int           stall;      // extra ct_valid cycles with ct_ready low
        int           inject_at;  // sample index for an ignored start pulse, -1 none
        int           abort_at;   // sample index for a reset, -1 none
        int           exp_lat;
        int           exp_vlen;
    } vec_t;

    vec_t vecs [6];

    serpent_round_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pt_in       (pt_in),
        .rk_addr     (rk_addr),
        .rk_data     (rk_data),
        .ct_valid    (ct_valid),
        .ct_ready    (ct_ready),
        .ct_out      (ct_out),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous subkey RAM with a read latency of one cycle.
    always @(posedge clk) begin
        if (rk_addr <= 6'd32) rk_data <= ram[rk_addr];
        else                  rk_data <= 128'd0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %032h expected %032h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Reference Serpent encryption that uses the current RAM contents as subkeys.
    function automatic logic [127:0] model(input logic [127:0] pt);
        logic [31:0] x [4];
        logic [31:0] y [4];
        logic [3:0]  nib;
        logic [3:0]  o;
        for (int w = 0; w < 4; w++) x[w] = pt[32*w +: 32];
        for (int r = 0; r < 32; r++) begin
            for (int w = 0; w < 4; w++) x[w] = x[w] ^ ram[r][32*w +: 32];
            for (int b = 0; b < 32; b++) begin
                nib = {x[3][b], x[2][b], x[1][b], x[0][b]};
                o = 4'(sb[r % 8][nib]);
                for (int w = 0; w < 4; w++) y[w][b] = o[w];
            end
            for (int w = 0; w < 4; w++) x[w] = y[w];
            if (r < 31) begin
                x[0] = rol(x[0], 13);
                x[2] = rol(x[2], 3);
                x[1] = x[1] ^ x[0] ^ x[2];
                x[3] = x[3] ^ x[2] ^ (x[0] << 3);
                x[1] = rol(x[1], 1);
                x[3] = rol(x[3], 7);
                x[0] = x[0] ^ x[1] ^ x[3];
                x[2] = x[2] ^ x[3] ^ (x[1] << 7);
                x[0] = rol(x[0], 5);
                x[2] = rol(x[2], 22);
            end
        end
        for (int w = 0; w < 4; w++) x[w] = x[w] ^ ram[32][32*w +: 32];
        return {x[3], x[2], x[1], x[0]};
    endfunction

    task automatic set_keys(input int mode);
        for (int n = 0; n <= 32; n++) begin
            if (mode == 0)      ram[n] = 128'd0;
            else if (mode == 1) ram[n] = {4{32'(n)}};
            else                ram[n] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Runs one block: accept, sequence checks, then ciphertext and handshake checks.
    task automatic run_block(input logic [127:0] pt, input int stall, input int inject_at,
                             input int abort_at, input bit noise, input int exp_lat,
                             input int exp_vlen, input string tag);
        logic [127:0] exp_ct;
        logic [127:0] first_ct;
        int  k;
        int  lat;
        int  vlen;
        int  bad_k;
        bit  flow_ok;
        bit  hold_ok;
        bit  quiet_ok;
        exp_ct = model(pt);
        k = 0;
        while (!start_ready && k < 100) begin
            tick();
            k++;
        end
        check_int({tag, "_start_ready"}, start_ready, 1);
        ct_ready    = (stall == 0);
        start_valid = 1'b1;
        pt_in       = pt;
        tick();
        start_valid = 1'b0;
        pt_in       = ~pt;
        k = 0;
        lat = -1;
        bad_k = -1;
        flow_ok = 1'b1;
        while (lat < 0 && k < 60) begin
            if (bad_k < 0 && rk_addr != ((k < 32) ? 6'(k) : 6'd32)) bad_k = k;
            if (start_ready || !busy) flow_ok = 1'b0;
            if (k == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_vec({tag, "_abort_ct_out"}, ct_out, 128'd0);
                check_int({tag, "_abort_ct_valid"}, ct_valid, 0);
                check_int({tag, "_abort_busy"}, busy, 0);
                check_int({tag, "_abort_start_ready"}, start_ready, 1);
                check_int({tag, "_abort_rk_addr"}, rk_addr, 0);
                quiet_ok = 1'b1;
                for (int q = 0; q < 40; q++) begin
                    tick();
                    if (ct_valid) quiet_ok = 1'b0;
                end
                check_int({tag, "_abort_no_ct_valid"}, quiet_ok, 1);
                return;
            end
            if (k == inject_at) begin
                start_valid = 1'b1;
                pt_in = pt ^ 128'h5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a;
            end
            if (noise) begin
                start_valid = 1'($urandom_range(0, 1));
                pt_in = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            start_valid = 1'b0;
            k++;
            if (ct_valid) lat = k;
        end
        check_int({tag, "_latency"}, lat, exp_lat);
        check_int({tag, "_rk_addr_trace_bad_idx"}, bad_k, -1);
        check_int({tag, "_busy_no_ready_inflight"}, flow_ok, 1);
        if (lat < 0) return;
        check_vec({tag, "_ct_out"}, ct_out, exp_ct);
        first_ct = ct_out;
        vlen = 0;
        hold_ok = 1'b1;
        for (int j = 0; j < stall + 20 && ct_valid; j++) begin
            vlen++;
            if (ct_out !== first_ct || start_ready || !busy) hold_ok = 1'b0;
            if (vlen > stall) ct_ready = 1'b1;
            tick();
        end
        check_int({tag, "_ct_valid_len"}, vlen, exp_vlen);
        check_int({tag, "_done_hold"}, hold_ok, 1);
        check_int({tag, "_idle_start_ready"}, start_ready, 1);
        check_int({tag, "_idle_busy"}, busy, 0);
        check_vec({tag, "_ct_out_kept"}, ct_out, exp_ct);
        ct_ready = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        start_valid = 1'b0;
        ct_ready    = 1'b0;
        pt_in       = 128'd0;
        set_keys(0);

        vecs[0] = '{128'd0, 0, 0, -1, -1, 34, 1};
        vecs[1] = '{128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef, 1, 0, -1, -1, 34, 1};
        vecs[2] = '{128'hdead_beef_cafe_f00d_0011_2233_4455_6677, 1, 10, -1, -1, 34, 11};
        vecs[3] = '{128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0, 1, 0, 11, -1, 34, 1};
        vecs[4] = '{128'h5555_aaaa_5555_aaaa_1234_5678_9abc_def0, 2, 0, -1, 18, 34, 1};
        vecs[5] = '{128'hffff_ffff_0000_0000_ffff_0000_00ff_ff00, 1, 2, -1, -1, 34, 3};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check_int("rst_start_ready", start_ready, 1);
        check_int("rst_busy", busy, 0);
        check_int("rst_ct_valid", ct_valid, 0);
        check_vec("rst_ct_out", ct_out, 128'd0);
        check_int("rst_rk_addr", rk_addr, 0);

        // Reset wins over an accept at the same edge
        start_valid = 1'b1;
        pt_in = 128'h1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_valid = 1'b0;
        check_int("rst_vs_accept_busy", busy, 0);
        check_int("rst_vs_accept_start_ready", start_ready, 1);

        // Directed table
        for (int v = 0; v < 6; v++) begin
            set_keys(vecs[v].key_mode);
            run_block(vecs[v].pt, vecs[v].stall, vecs[v].inject_at, vecs[v].abort_at,
                      1'b0, vecs[v].exp_lat, vecs[v].exp_vlen, $sformatf("vec%0d", v));
        end

        // Reset wins over a handshake in DONE, and the ciphertext is cleared
        set_keys(1);
        start_valid = 1'b1;
        pt_in = 128'h77;
        tick();
        start_valid = 1'b0;
        for (int k = 0; k < 40 && !ct_valid; k++) tick();
        check_int("done_reached", ct_valid, 1);
        ct_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ct_ready = 1'b0;
        check_int("rst_in_done_ct_valid", ct_valid, 0);
        check_vec("rst_in_done_ct_out", ct_out, 128'd0);
        check_int("rst_in_done_start_ready", start_ready, 1);

        // Random plaintexts, subkeys, stalls and start_valid noise while in flight
        for (int t = 0; t < 100; t++) begin
            int st;
            st = int'($urandom_range(0, 3));
            set_keys(2);
            run_block({$urandom, $urandom, $urandom, $urandom}, st, -1, -1, 1'b1,
                      34, st + 1, $sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serpent_round_ctrl.md
SERPENT_ROUND_CTRL -- requirements
Module: serpent_round_ctrl

Interface
REQ-001 SHALL have no parameters: 128-bit block, 32 rounds and 33 subkeys are fixed.
REQ-002 SHALL have port `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port `start_valid`, input, 1 bit: plaintext offered.
REQ-005 SHALL have port `start_ready`, output, 1 bit: controller can accept plaintext.
REQ-006 SHALL have port `pt_in`, input, 128 bits: plaintext {X3,X2,X1,X0}, with X0 in bits [31:0].
REQ-007 SHALL have port `rk_addr`, output, 6 bits: subkey index to the external synchronous subkey RAM.
REQ-008 SHALL have port `rk_data`, input, 128 bits: subkey K[rk_addr presented in the previous cycle].
REQ-009 SHALL have port `ct_valid`, output, 1 bit: ciphertext available.
REQ-010 SHALL have port `ct_ready`, input, 1 bit: consumer accepts the ciphertext.
REQ-011 SHALL have port `ct_out`, output, 128 bits: ciphertext {Y3,Y2,Y1,Y0}.
REQ-012 SHALL have port `busy`, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, PRIME, ROUND, FINAL and DONE, with a 5-bit round counter `r`.
REQ-014 SHALL drive start_ready=1 only in IDLE; an accept occurs when start_valid && start_ready at a clock edge.
REQ-015 On accept, SHALL: register state<=pt_in, set rk_addr<=0 and r<=0, and move to PRIME.
REQ-016 SHALL make rk_addr a register that increments once per cycle while in PRIME and ROUND, sequencing 0,1,…,32, and holds at 32 afterwards.
REQ-017 SHALL spend exactly one cycle in PRIME, then move to ROUND; the subkey RAM latency is exactly one cycle.
REQ-018 For ROUND with r in 0..30, SHALL update state<=LT(S_(r mod 8)(state ^ rk_data)), where rk_data = K_r, then r<=r+1.
REQ-019 For ROUND with r=31, SHALL update state<=S_7(state ^ K_31) with no LT, then move to FINAL.
REQ-020 In FINAL, SHALL update state<=state ^ rk_data (K_32), load ct_out<=that value, set ct_valid<=1, and move to DONE.
REQ-021 SHALL apply the S-boxes bitsliced: for each bit i in 0..31, nibble {X3[i],X2[i],X1[i],X0[i]} (X0 is the LSB) maps through S0..S7 as tabulated in the Serpent submission.
REQ-022 SHALL implement LT as the standard Serpent linear transform:
- X0<<<13, X2<<<3
- X1^=X0^X2, X3^=X2^(X0<<3)
- X1<<<1, X3<<<7
- X0^=X1^X3, X2^=X3^(X1<<7)
- X0<<<5, X2<<<22
(<<< is a 32-bit rotate; << is a logical shift.)
REQ-023 In DONE, SHALL hold ct_valid=1 and keep ct_out stable until ct_ready=1; on that edge it SHALL clear ct_valid and move to IDLE.
REQ-024 SHALL give a latency of 34 cycles: ct_valid rises at the 34th rising edge after the accepting edge, and the earliest next accept is the edge after the ct_ready handshake.
REQ-025 SHALL ignore start_valid in every state except IDLE and SHALL NOT overlap or queue blocks.
REQ-026 When ct_ready is already high on the cycle ct_valid rises, the handshake SHALL complete on the next edge, so ct_valid is high for exactly one cycle.
REQ-027 SHALL keep ct_out holding the last ciphertext after the handshake until the next FINAL overwrites it.
REQ-028 SHALL be insensitive to rk_data in IDLE, PRIME and DONE.

Reset
REQ-029 When rst=1 at a clock edge, SHALL force: state IDLE, r=0, rk_addr=0, internal state register=0, ct_out=0, ct_valid=0 and busy=0; start_ready SHALL be 1 on the following cycle.
REQ-030 A reset in any state, including mid-ROUND or DONE, SHALL discard the block in flight and produce no ct_valid for it.
REQ-031 Reset SHALL take priority over an accept or a handshake occurring at the same edge.

Verification
REQ-032 Bench: subkey RAM of all zeros, pt_in=0, ct_ready=1 -> ct_valid for exactly one cycle at edge 34 after accept, and ct_out equal to the golden model.
REQ-033 Bench: RAM K_n = {4{32'h0000_00nn}}, pt_in=128'h0123…CDEF -> the rk_addr trace is 0..32 on consecutive cycles, and ct_out matches the golden model.
REQ-034 Bench: ct_ready=0 for 10 cycles after ct_valid -> ct_valid and ct_out stay constant, start_ready=0 and busy=1; when ct_ready goes high -> IDLE one edge later.
REQ-035 Bench: start_valid pulsed at round 10 with a different pt_in -> ignored, and the result corresponds to the first plaintext.
REQ-036 Bench: rst asserted at r=17 -> one edge later ct_out=0, ct_valid=0, busy=0 and start_ready=1; a new block then completes correctly in 34 cycles.
REQ-037 Bench: 100 random plaintexts and subkeys with random ct_ready stalls -> every ct_out matches the golden model, and no accept occurs outside IDLE.
